// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// State encoding, default geometry and the even-parity helper.
package reg_file_pkg;

   localparam int WIDTH_DEF  = 32;
   localparam int DEPTH_DEF  = 32;
   localparam int NUM_RD_DEF = 2;
   localparam int PAR_MAXW   = 128;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   // Zero-extension does not change parity, so one wide helper serves any WIDTH.
   function automatic logic par_f(input logic [PAR_MAXW-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port with write bypass and x0/busy forcing.
// REG_FILE_MP_PARITY_EN adds a parity-error flag for stored reads.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AW    = 5,
   parameter int SW    = WIDTH
) (
   input  logic             busy,
   input  logic [AW-1:0]    rd_addr,
   input  logic [SW-1:0]    ent,
   input  logic             we_a,
   input  logic [AW-1:0]    wa_a,
   input  logic [WIDTH-1:0] wd_a,
   input  logic             we_b,
   input  logic [AW-1:0]    wa_b,
   input  logic [WIDTH-1:0] wd_b,
`ifdef REG_FILE_MP_PARITY_EN
   output logic             perr,
`endif
   output logic [WIDTH-1:0] rd_data
);

   logic hit_a;
   logic hit_b;

   assign hit_a = we_a && (wa_a == rd_addr);
   assign hit_b = we_b && (wa_b == rd_addr);

   always_comb begin
      rd_data = '0;
`ifdef REG_FILE_MP_PARITY_EN
      perr    = 1'b0;
`endif
      if (busy || rd_addr == '0) begin
         rd_data = '0;
      end else if (hit_b) begin
         rd_data = wd_b;
      end else if (hit_a) begin
         rd_data = wd_a;
      end else begin
         rd_data = ent[WIDTH-1:0];
`ifdef REG_FILE_MP_PARITY_EN
         perr    = ent[SW-1] ^ par_f(PAR_MAXW'(ent[WIDTH-1:0]));
`endif
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD read ports,
// bypass and post-reset clear sweep. Option: REG_FILE_MP_PARITY_EN.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int NUM_RD = NUM_RD_DEF,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              wr_en,
   input  logic [2*AW-1:0]         wr_addr,
   input  logic [2*WIDTH-1:0]      wr_data,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
`ifdef REG_FILE_MP_PARITY_EN
   output logic [NUM_RD-1:0]       perr,
`endif
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic                    busy
);

`ifdef REG_FILE_MP_PARITY_EN
   localparam int SW = WIDTH + 1;
`else
   localparam int SW = WIDTH;
`endif

   state_t          state, state_nx;
   logic [AW-1:0]   clr_cnt, cnt_nx;
   logic [SW-1:0]   mem [DEPTH];

   logic [AW-1:0]    wa_a, wa_b;
   logic [WIDTH-1:0] wd_a, wd_b;
   logic [SW-1:0]    ent_a, ent_b;
   logic             run, we_a, we_b;

   assign wa_a = wr_addr[AW-1:0];
   assign wa_b = wr_addr[2*AW-1:AW];
   assign wd_a = wr_data[WIDTH-1:0];
   assign wd_b = wr_data[2*WIDTH-1:WIDTH];

   assign run  = (state == RUN);
   assign busy = (state == CLEAR);
   assign we_a = run && wr_en[0] && (wa_a != '0);
   assign we_b = run && wr_en[1] && (wa_b != '0);

`ifdef REG_FILE_MP_PARITY_EN
   assign ent_a = {par_f(PAR_MAXW'(wd_a)), wd_a};
   assign ent_b = {par_f(PAR_MAXW'(wd_b)), wd_b};
`else
   assign ent_a = wd_a;
   assign ent_b = wd_b;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = clr_cnt;
      case (state)
         CLEAR: begin
            cnt_nx = clr_cnt + AW'(1);
            if (clr_cnt == AW'(DEPTH - 1)) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= cnt_nx;
      end
   end

   // Port B is written last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
         end else begin
            if (we_a) mem[wa_a] <= ent_a;
            if (we_b) mem[wa_b] <= ent_b;
         end
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = rd_addr[i*AW +: AW];

      reg_file_rd_port #(
         .WIDTH (WIDTH),
         .AW    (AW),
         .SW    (SW)
      ) u_rd (
         .busy    (busy),
         .rd_addr (ra),
         .ent     (mem[ra]),
         .we_a    (we_a),
         .wa_a    (wa_a),
         .wd_a    (wd_a),
         .we_b    (we_b),
         .wa_b    (wa_b),
         .wd_b    (wd_b),
`ifdef REG_FILE_MP_PARITY_EN
         .perr    (perr[i]),
`endif
         .rd_data (rd_data[i*WIDTH +: WIDTH])
      );
   end

endmodule
